// File: rtl/ddr3_clk_rst_seq.sv
// ddr3_clk_rst_seq: DDR3 clock/reset sequencer.
// Synchronizes pll_lock and waits for a stable lock before releasing the
// DDR3 controller reset. Once calibration completes, it releases the
// consumer reset.
// Optional feature macro: DDR3_RST_SEQ_CALIB_TIMEOUT_EN enables the
// calibration timeout, DDR3 reset retry and sticky fault path.
module ddr3_clk_rst_seq #(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned STABLE_CYCLES = 1024,
  parameter int unsigned CALIB_TIMEOUT = 1048576,
  parameter int unsigned RST_PULSE     = 64,
  parameter int unsigned RETRY_MAX     = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pll_lock,
  input  logic       calib_done,
  output logic       ddr_rst,
  output logic       sys_rst,
  output logic       fault,
  output logic [2:0] state,
  output logic [3:0] retry_cnt,
  output logic [7:0] lock_loss_cnt
);

  localparam int unsigned SW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_WAIT_LOCK  = 3'd0,
    S_STABLE     = 3'd1,
    S_WAIT_CALIB = 3'd2,
    S_DDR_RETRY  = 3'd3,
    S_RUN        = 3'd4,
    S_FAULT      = 3'd5
  } state_t;

  state_t                 st;
  state_t                 st_n;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lock_s;
  logic [SW-1:0]          stab_cnt;
  logic                   stab_done;
  logic                   lock_lost;

  assign lock_s    = sync_q[SYNC_STAGES-1];
  assign stab_done = (stab_cnt == SW'(STABLE_CYCLES - 1));
  assign state     = st;

  // Lock loss only counts once the sequencer has left WAIT_LOCK and before FAULT
  assign lock_lost = !lock_s && (st == S_STABLE || st == S_WAIT_CALIB ||
                                 st == S_DDR_RETRY || st == S_RUN);

`ifdef DDR3_RST_SEQ_CALIB_TIMEOUT_EN
  localparam int unsigned TW = (CALIB_TIMEOUT > 1) ? $clog2(CALIB_TIMEOUT) : 1;
  localparam int unsigned PW = (RST_PULSE > 1) ? $clog2(RST_PULSE) : 1;

  logic [TW-1:0] cal_tmr;
  logic [PW-1:0] pulse_cnt;
  logic          timeout;
  logic          pulse_done;
  logic          retry_ok;

  assign timeout    = (cal_tmr == TW'(CALIB_TIMEOUT - 1));
  assign pulse_done = (pulse_cnt == PW'(RST_PULSE - 1));
  assign retry_ok   = (retry_cnt < 4'(RETRY_MAX));
`endif

  // pll_lock synchronizer chain
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pll_lock};
    end
  end

  // Next-state selection; lock loss has priority over every other exit
  always_comb begin
    st_n = st;
    case (st)
      S_WAIT_LOCK: begin
        if (lock_s) st_n = S_STABLE;
      end
      S_STABLE: begin
        if (!lock_s)        st_n = S_WAIT_LOCK;
        else if (stab_done) st_n = S_WAIT_CALIB;
      end
      S_WAIT_CALIB: begin
        if (!lock_s)         st_n = S_WAIT_LOCK;
        else if (calib_done) st_n = S_RUN;
`ifdef DDR3_RST_SEQ_CALIB_TIMEOUT_EN
        else if (timeout)    st_n = retry_ok ? S_DDR_RETRY : S_FAULT;
`endif
      end
      S_RUN: begin
        if (!lock_s) st_n = S_WAIT_LOCK;
      end
`ifdef DDR3_RST_SEQ_CALIB_TIMEOUT_EN
      S_DDR_RETRY: begin
        if (!lock_s)         st_n = S_WAIT_LOCK;
        else if (pulse_done) st_n = S_WAIT_CALIB;
      end
      S_FAULT: begin
        st_n = S_FAULT;
      end
`endif
      default: st_n = S_WAIT_LOCK;
    endcase
  end

  // State, registered resets decoded from the next state, stability and loss counters
  always_ff @(posedge clk) begin
    if (rst) begin
      st            <= S_WAIT_LOCK;
      ddr_rst       <= 1'b1;
      sys_rst       <= 1'b1;
      stab_cnt      <= '0;
      lock_loss_cnt <= '0;
    end else begin
      st      <= st_n;
      ddr_rst <= !(st_n == S_WAIT_CALIB || st_n == S_RUN);
      sys_rst <= (st_n != S_RUN);
      if (st == S_STABLE && st_n == S_STABLE) begin
        stab_cnt <= stab_cnt + SW'(1);
      end else begin
        stab_cnt <= '0;
      end
      if (lock_lost && lock_loss_cnt != 8'hFF) begin
        lock_loss_cnt <= lock_loss_cnt + 8'd1;
      end
    end
  end

`ifdef DDR3_RST_SEQ_CALIB_TIMEOUT_EN
  // Calibration timer, retry pulse length, retry count and sticky fault
  always_ff @(posedge clk) begin
    if (rst) begin
      cal_tmr   <= '0;
      pulse_cnt <= '0;
      retry_cnt <= '0;
      fault     <= 1'b0;
    end else begin
      if (st == S_WAIT_CALIB && st_n == S_WAIT_CALIB) begin
        cal_tmr <= cal_tmr + TW'(1);
      end else begin
        cal_tmr <= '0;
      end
      if (st == S_DDR_RETRY && st_n == S_DDR_RETRY) begin
        pulse_cnt <= pulse_cnt + PW'(1);
      end else begin
        pulse_cnt <= '0;
      end
      if (st == S_WAIT_CALIB && st_n == S_DDR_RETRY) begin
        retry_cnt <= retry_cnt + 4'd1;
      end
      fault <= (st_n == S_FAULT);
    end
  end
`else
  assign fault     = 1'b0;
  assign retry_cnt = 4'd0;
`endif

endmodule

// File: tb/tb_ddr3_clk_rst_seq.sv
// Directed bench for ddr3_clk_rst_seq (SYNC_STAGES=2, STABLE_CYCLES=16,
// CALIB_TIMEOUT=64, RST_PULSE=8, RETRY_MAX=2).
module tb_ddr3_clk_rst_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       pll_lock;
  logic       calib_done;
  logic       ddr_rst;
  logic       sys_rst;
  logic       fault;
  logic [2:0] state;
  logic [3:0] retry_cnt;
  logic [7:0] lock_loss_cnt;

  int total = 0;
  int bad   = 0;

  ddr3_clk_rst_seq #(
    .SYNC_STAGES  (2),
    .STABLE_CYCLES(16),
    .CALIB_TIMEOUT(64),
    .RST_PULSE    (8),
    .RETRY_MAX    (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .pll_lock     (pll_lock),
    .calib_done   (calib_done),
    .ddr_rst      (ddr_rst),
    .sys_rst      (sys_rst),
    .fault        (fault),
    .state        (state),
    .retry_cnt    (retry_cnt),
    .lock_loss_cnt(lock_loss_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    pll_lock   = 1'b0;
    calib_done = 1'b0;
    tick(2);
    rst = 1'b0;
  endtask

  // Raise pll_lock and count edges until ddr_rst falls: 2 sync + 1 entry + 16 stable
  task automatic bring_up(input string tag);
    int n;
    n = 0;
    pll_lock = 1'b1;
    while (ddr_rst && n < 100) begin
      tick(1);
      n++;
    end
    chk(tag, 32'(n), 32'd19);
    chk({tag, "_state"}, 32'(state), 32'd2);
  endtask

  initial begin
    int n;
    do_reset();
    tick(1);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_ddr", 32'(ddr_rst), 32'd1);
    chk("rst_sys", 32'(sys_rst), 32'd1);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_retry", 32'(retry_cnt), 32'd0);
    chk("rst_llc", 32'(lock_loss_cnt), 32'd0);

    // Basic bring-up, calib_done five cycles after ddr_rst release
    bring_up("bringup");
    chk("wc_sys", 32'(sys_rst), 32'd1);
    tick(5);
    chk("wc_hold", 32'(state), 32'd2);
    calib_done = 1'b1;
    tick(1);
    chk("run_state", 32'(state), 32'd4);
    chk("run_sys", 32'(sys_rst), 32'd0);
    chk("run_ddr", 32'(ddr_rst), 32'd0);
    calib_done = 1'b0;
    tick(3);
    chk("run_ignore_calib", 32'(state), 32'd4);

    // Lock loss in RUN reaches reset within SYNC_STAGES+1 edges
    pll_lock = 1'b0;
    n = 0;
    while (!ddr_rst && n < 10) begin
      tick(1);
      n++;
    end
    chk("run_loss_lat", 32'(n), 32'd3);
    chk("run_loss_sys", 32'(sys_rst), 32'd1);
    chk("run_loss_state", 32'(state), 32'd0);
    chk("run_loss_llc", 32'(lock_loss_cnt), 32'd1);

    // Lock drop at stability count 8, then full 16-cycle restart
    pll_lock = 1'b1;
    n = 0;
    while (state != 3'd1 && n < 20) begin
      tick(1);
      n++;
    end
    chk("stable_entry", 32'(n), 32'd3);
    tick(6);
    pll_lock = 1'b0;
    tick(3);
    chk("stable_loss_state", 32'(state), 32'd0);
    chk("stable_loss_llc", 32'(lock_loss_cnt), 32'd2);
    bring_up("relock");
    calib_done = 1'b1;
    tick(1);
    chk("relock_run", 32'(state), 32'd4);
    calib_done = 1'b0;

    // Saturation of lock_loss_cnt
    pll_lock = 1'b0;
    tick(4);
    chk("llc_3", 32'(lock_loss_cnt), 32'd3);
    for (int i = 0; i < 300; i++) begin
      pll_lock = 1'b1;
      tick(4);
      pll_lock = 1'b0;
      tick(4);
      if (i == 249) chk("llc_253", 32'(lock_loss_cnt), 32'd253);
    end
    chk("llc_sat", 32'(lock_loss_cnt), 32'd255);
    chk("llc_sat_state", 32'(state), 32'd0);
    do_reset();
    chk("llc_cleared", 32'(lock_loss_cnt), 32'd0);

    // Reset in RUN takes effect on the next edge
    bring_up("bringup2");
    calib_done = 1'b1;
    tick(1);
    chk("run2_state", 32'(state), 32'd4);
    rst = 1'b1;
    tick(1);
    chk("rst_run_state", 32'(state), 32'd0);
    chk("rst_run_ddr", 32'(ddr_rst), 32'd1);
    chk("rst_run_sys", 32'(sys_rst), 32'd1);
    do_reset();

`ifdef DDR3_RST_SEQ_CALIB_TIMEOUT_EN
    // Two retry windows of 8 cycles, then FAULT
    bring_up("to_bringup");
    for (int r = 1; r <= 2; r++) begin
      tick(63);
      chk("to_wait_end", 32'(state), 32'd2);
      tick(1);
      chk("to_retry_state", 32'(state), 32'd3);
      chk("to_retry_cnt", 32'(retry_cnt), 32'(r));
      n = 0;
      while (state == 3'd3 && n < 50) begin
        chk("to_retry_ddr", 32'(ddr_rst), 32'd1);
        tick(1);
        n++;
      end
      chk("to_pulse_len", 32'(n), 32'd8);
      chk("to_back_wc", 32'(state), 32'd2);
    end
    tick(63);
    chk("to_last_wait", 32'(state), 32'd2);
    tick(1);
    chk("fault_state", 32'(state), 32'd5);
    chk("fault_flag", 32'(fault), 32'd1);
    chk("fault_retry", 32'(retry_cnt), 32'd2);
    chk("fault_ddr", 32'(ddr_rst), 32'd1);
    pll_lock = 1'b0;
    tick(5);
    chk("fault_sticky", 32'(state), 32'd5);
    chk("fault_llc", 32'(lock_loss_cnt), 32'd0);
    do_reset();
    chk("fault_rst_state", 32'(state), 32'd0);
    chk("fault_rst_flag", 32'(fault), 32'd0);
    chk("fault_rst_retry", 32'(retry_cnt), 32'd0);

    // calib_done in the exact timeout cycle wins
    bring_up("tie_bringup");
    tick(63);
    calib_done = 1'b1;
    tick(1);
    chk("tie_state", 32'(state), 32'd4);
    chk("tie_retry", 32'(retry_cnt), 32'd0);
    calib_done = 1'b0;
`else
    // Without the timeout feature WAIT_CALIB waits indefinitely
    bring_up("nto_bringup");
    tick(10000);
    chk("nto_state", 32'(state), 32'd2);
    chk("nto_fault", 32'(fault), 32'd0);
    chk("nto_retry", 32'(retry_cnt), 32'd0);
    chk("nto_ddr", 32'(ddr_rst), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ddr3_clk_rst_seq.md
DDR3_CLK_RST_SEQ -- requirements
Module: ddr3_clk_rst_seq

Interface
REQ-001 Parameter SYNC_STAGES, default 2: number of synchronizer flops on pll_lock (minimum 2).
REQ-002 Parameter STABLE_CYCLES, default 1024: consecutive synchronized-lock cycles required before DDR3 reset release (minimum 2).
REQ-003 Parameter CALIB_TIMEOUT, default 1048576: WAIT_CALIB cycles allowed before a retry (minimum 2).
REQ-004 Parameter RST_PULSE, default 64: ddr_rst hold length in DDR_RETRY (minimum 1).
REQ-005 Parameter RETRY_MAX, default 3: calibration retries before FAULT (range 0..15).
REQ-006 clk  input  1  DDR3 PLL clkout0; the only clock of the block.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 pll_lock  input  1  PLL lock; asynchronous to clk.
REQ-009 calib_done  input  1  DDR3 controller calibration complete; synchronous to clk.
REQ-010 ddr_rst  output  1  active-high reset to the DDR3 controller; registered.
REQ-011 sys_rst  output  1  active-high reset to DDR3 consumers; registered.
REQ-012 fault  output  1  sticky calibration failure flag; registered.
REQ-013 state  output  3  current state code; registered.
REQ-014 retry_cnt  output  4  calibration retries used.
REQ-015 lock_loss_cnt  output  8  lock-loss events seen after STABLE was entered; saturates at 255.

Function
REQ-016 pll_lock SHALL pass through SYNC_STAGES flops to produce lock_s; all decisions use lock_s only.
REQ-017 State codes SHALL be WAIT_LOCK=0, STABLE=1, WAIT_CALIB=2, DDR_RETRY=3, RUN=4, FAULT=5; codes 6-7 SHALL transition to WAIT_LOCK.
REQ-018 WAIT_LOCK: ddr_rst=1, sys_rst=1; lock_s=1 -> STABLE with the stability counter cleared.
REQ-019 STABLE: the counter increments each cycle lock_s=1; at count STABLE_CYCLES-1 -> WAIT_CALIB.
REQ-020 WAIT_CALIB: ddr_rst=0, sys_rst=1; the calibration timer increments each cycle; calib_done=1 -> RUN.
REQ-021 RUN: ddr_rst=0, sys_rst=0; RUN is held while lock_s=1, and calib_done deassertion is ignored.
REQ-022 DDR_RETRY: ddr_rst=1, sys_rst=1 for exactly RST_PULSE cycles, then -> WAIT_CALIB with the timer cleared.
REQ-023 FAULT: ddr_rst=1, sys_rst=1, fault=1; FAULT is left only by rst, and lock_s is ignored.
REQ-024 Outputs are registered: each output takes its new-state value in the first cycle the new state is visible on state.
REQ-025 In STABLE, WAIT_CALIB, DDR_RETRY or RUN, lock_s=0 SHALL force WAIT_LOCK next cycle, increment lock_loss_cnt and clear both counters; this has priority over every other transition.
REQ-026 If calib_done=1 and timeout occur in the same cycle, calib_done SHALL win (-> RUN).
REQ-027 retry_cnt SHALL clear only on rst; lock loss does not clear it.
REQ-028 Counter widths SHALL be $clog2 of the respective parameter, with no wrap inside a state.

Reset
REQ-029 rst=1 at a clock edge SHALL set state=WAIT_LOCK, ddr_rst=1, sys_rst=1, fault=0, retry_cnt=0, lock_loss_cnt=0, all counters and synchronizer flops to 0.
REQ-030 rst asserted mid-sequence, including in FAULT or RUN, SHALL take effect on the next edge with the values of REQ-029.

Configuration
REQ-031 With macro DDR3_RST_SEQ_CALIB_TIMEOUT_EN defined, the calibration timer, DDR_RETRY, FAULT and retry logic SHALL be present, and WAIT_CALIB timeout at CALIB_TIMEOUT-1 without calib_done SHALL go to DDR_RETRY (retry_cnt+1) if retry_cnt<RETRY_MAX, else to FAULT.
REQ-032 Without DDR3_RST_SEQ_CALIB_TIMEOUT_EN, WAIT_CALIB SHALL wait indefinitely, fault and retry_cnt SHALL be tied to 0, and states 3 and 5 SHALL be unreachable.

Verification (STABLE_CYCLES=16, CALIB_TIMEOUT=64, RST_PULSE=8, RETRY_MAX=2)
REQ-033 pll_lock rises at cycle 10 and calib_done rises 5 cycles after ddr_rst falls -> ddr_rst falls at cycle 10+2+16+1 (±1 per synchronizer alignment); state=4 and sys_rst=0 one cycle after calib_done.
REQ-034 pll_lock drops for 3 cycles at count 8 of STABLE -> return to WAIT_LOCK; lock_loss_cnt=1; the full 16-cycle count restarts after relock.
REQ-035 Macro defined, calib_done held 0 -> two DDR_RETRY windows of exactly 8 cycles each with ddr_rst=1, then state=5, fault=1, retry_cnt=2; rst clears all.
REQ-036 calib_done asserted in the exact timeout cycle -> state=4, retry_cnt unchanged.
REQ-037 In RUN, pll_lock drops -> ddr_rst=1 and sys_rst=1 within SYNC_STAGES+1 cycles; 300 drops -> lock_loss_cnt=255.
REQ-038 Macro undefined, calib_done held 0 for 10000 cycles -> state stays 2, fault=0.
